// File: rtl/alu_pkg.sv
// Shared encodings for the ALU operation sequencer: ALU op codes, decode
// aluop classes, branch funct3 codes and the sequencer FSM states.
package alu_pkg;

  localparam int OP_W = 4;

  // ALU operation select codes
  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0110;
  localparam logic [OP_W-1:0] OP_SLT = 4'b0111;  // unsigned set-less-than
  localparam logic [OP_W-1:0] OP_NOR = 4'b1100;

  // Decode-stage aluop classes
  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  // R/I-type funct3 codes
  localparam logic [2:0] F3_ADD   = 3'b000;
  localparam logic [2:0] F3_SLT_S = 3'b010;
  localparam logic [2:0] F3_SLT_U = 3'b011;
  localparam logic [2:0] F3_OR    = 3'b110;
  localparam logic [2:0] F3_AND   = 3'b111;

  // Branch funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational translation of aluop/funct3/funct7_5 into an ALU op code,
// plus flags telling the sequencer how to post-process the ALU result.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [1:0]      aluop_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7_5_i,
  output logic [OP_W-1:0] op_o,
  output logic            is_branch_o,
  output logic            slt_signed_o,
  output logic            illegal_o
);

  // Map each encoding to an op; unsupported encodings fall back to AND
  always_comb begin
    op_o         = OP_AND;
    is_branch_o  = 1'b0;
    slt_signed_o = 1'b0;
    illegal_o    = 1'b0;
    case (aluop_i)
      ALUOP_LDST: op_o = OP_ADD;
      ALUOP_RTYPE, ALUOP_ITYPE: begin
        case (funct3_i)
          F3_ADD: begin
            // Only R-type uses bit 30 to select SUB; for I-type it is immediate data
            if ((aluop_i == ALUOP_RTYPE) && funct7_5_i) op_o = OP_SUB;
            else                                        op_o = OP_ADD;
          end
          F3_AND:   op_o = OP_AND;
          F3_OR:    op_o = OP_OR;
          F3_SLT_U: op_o = OP_SLT;
          F3_SLT_S: begin
            // Signed compare is derived from a SUB plus overflow correction
            op_o         = OP_SUB;
            slt_signed_o = 1'b1;
          end
          default:  illegal_o = 1'b1;
        endcase
      end
      default: begin  // ALUOP_BRANCH
        case (funct3_i)
          F3_BEQ, F3_BNE, F3_BLT, F3_BGE: begin
            op_o        = OP_SUB;
            is_branch_o = 1'b1;
          end
          F3_BLTU, F3_BGEU: begin
            op_o        = OP_SLT;
            is_branch_o = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue side of the ALU interface: accepts a decode request, drives the
// external combinational ALU from registers for one cycle, captures the
// result / branch decision and returns it on a response handshake.
//
// Handshakes: a request transfers on a rising edge where req_valid and
// req_ready are both 1; a response transfers on a rising edge where rsp_valid
// and rsp_ready are both 1. rsp_* are held stable while rsp_valid is 1 and
// rsp_ready is 0. req_ready is 1 only in IDLE.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = OP_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_aluop,
  input  logic [2:0]            req_funct3,
  input  logic                  req_funct7_5,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic [OP_WIDTH-1:0]   alu_operation,
  output logic [DATA_WIDTH-1:0] alu_in_x,
  output logic [DATA_WIDTH-1:0] alu_in_y,
  input  logic [DATA_WIDTH-1:0] alu_out_s,
  input  logic                  alu_ng,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_taken,
  output logic                  rsp_illegal,
  output logic [1:0]            dbg_state
);

  localparam int MSB = DATA_WIDTH - 1;

  state_e state_q, state_d;

  logic [OP_W-1:0] dec_op;
  logic            dec_branch, dec_slt_signed, dec_illegal;

  logic [OP_WIDTH-1:0]   alu_operation_q;
  logic [DATA_WIDTH-1:0] alu_in_x_q, alu_in_y_q;
  logic [2:0]            funct3_q;
  logic                  branch_q, slt_signed_q, illegal_q;

  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_taken_q, rsp_taken_d;
  logic                  rsp_illegal_q;

  logic accept, ovf, lt_s, zero;

  alu_op_decoder u_dec (
    .aluop_i      (req_aluop),
    .funct3_i     (req_funct3),
    .funct7_5_i   (req_funct7_5),
    .op_o         (dec_op),
    .is_branch_o  (dec_branch),
    .slt_signed_o (dec_slt_signed),
    .illegal_o    (dec_illegal)
  );

  assign accept = req_valid && (state_q == ST_IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: IDLE -> EXEC on request, EXEC -> RESP always, RESP -> IDLE on consume
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state
  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    dbg_state = state_q;
  end

  // Signed less-than from the SUB result: sign bit corrected by overflow
  always_comb begin
    ovf  = (alu_in_x_q[MSB] != alu_in_y_q[MSB]) && (alu_out_s[MSB] != alu_in_x_q[MSB]);
    lt_s = alu_ng ^ ovf;
    zero = (alu_out_s == '0);
  end

  // Result and branch decision formed from the ALU output during EXEC
  always_comb begin
    rsp_result_d = alu_out_s;
    rsp_taken_d  = 1'b0;
    if (illegal_q) begin
      rsp_result_d = '0;
    end else if (slt_signed_q) begin
      rsp_result_d = {{(DATA_WIDTH-1){1'b0}}, lt_s};
    end
    if (branch_q && !illegal_q) begin
      case (funct3_q)
        F3_BEQ:  rsp_taken_d = zero;
        F3_BNE:  rsp_taken_d = !zero;
        F3_BLT:  rsp_taken_d = lt_s;
        F3_BGE:  rsp_taken_d = !lt_s;
        F3_BLTU: rsp_taken_d = alu_out_s[0];
        F3_BGEU: rsp_taken_d = !alu_out_s[0];
        default: rsp_taken_d = 1'b0;
      endcase
    end
  end

  // ALU drive registers: loaded on accept, otherwise hold last values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_operation_q <= OP_AND;
      alu_in_x_q      <= '0;
      alu_in_y_q      <= '0;
      funct3_q        <= '0;
      branch_q        <= 1'b0;
      slt_signed_q    <= 1'b0;
      illegal_q       <= 1'b0;
    end else if (accept) begin
      alu_operation_q <= dec_op;
      alu_in_x_q      <= req_a;
      alu_in_y_q      <= req_b;
      funct3_q        <= req_funct3;
      branch_q        <= dec_branch;
      slt_signed_q    <= dec_slt_signed;
      illegal_q       <= dec_illegal;
    end
  end

  // Response registers: captured only in EXEC so they stay stable in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result_q  <= '0;
      rsp_taken_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
    end else if (state_q == ST_EXEC) begin
      rsp_result_q  <= rsp_result_d;
      rsp_taken_q   <= rsp_taken_d;
      rsp_illegal_q <= illegal_q;
    end
  end

  assign alu_operation = alu_operation_q;
  assign alu_in_x      = alu_in_x_q;
  assign alu_in_y      = alu_in_y_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_taken     = rsp_taken_q;
  assign rsp_illegal   = rsp_illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed and random checks of alu_op_sequencer against a behavioural ALU
// and an independent instruction-level reference model.
module tb_alu_op_sequencer;

  localparam int DW = 32;
  localparam int EW = 4 + 1 + 1 + DW;  // {op, illegal, taken, result}

  logic          clk;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [1:0]    req_aluop;
  logic [2:0]    req_funct3;
  logic          req_funct7_5;
  logic [DW-1:0] req_a, req_b;
  logic [3:0]    alu_operation;
  logic [DW-1:0] alu_in_x, alu_in_y, alu_out_s;
  logic          alu_ng;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_taken, rsp_illegal;
  logic [1:0]    dbg_state;

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  alu_op_sequencer #(.DATA_WIDTH(DW), .OP_WIDTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_aluop     (req_aluop),
    .req_funct3    (req_funct3),
    .req_funct7_5  (req_funct7_5),
    .req_a         (req_a),
    .req_b         (req_b),
    .alu_operation (alu_operation),
    .alu_in_x      (alu_in_x),
    .alu_in_y      (alu_in_y),
    .alu_out_s     (alu_out_s),
    .alu_ng        (alu_ng),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_taken     (rsp_taken),
    .rsp_illegal   (rsp_illegal),
    .dbg_state     (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ALU
  always_comb begin
    alu_out_s = '0;
    case (alu_operation)
      4'b0000: alu_out_s = alu_in_x & alu_in_y;
      4'b0001: alu_out_s = alu_in_x | alu_in_y;
      4'b0010: alu_out_s = alu_in_x + alu_in_y;
      4'b0110: alu_out_s = alu_in_x - alu_in_y;
      4'b0111: alu_out_s = (alu_in_x < alu_in_y) ? 32'd1 : 32'd0;
      4'b1100: alu_out_s = ~(alu_in_x | alu_in_y);
      default: alu_out_s = '0;
    endcase
  end
  assign alu_ng = alu_out_s[DW-1];

  // Reference model: expected {op, illegal, taken, result} for one request
  function automatic logic [EW-1:0] model(input logic [1:0] aluop, input logic [2:0] f3,
                                          input logic f7, input logic [DW-1:0] a,
                                          input logic [DW-1:0] b);
    logic [3:0]    op;
    logic          ill, tk;
    logic [DW-1:0] res;
    op = 4'b0000; ill = 1'b0; tk = 1'b0; res = '0;
    if (aluop == 2'b00) begin
      op = 4'b0010; res = a + b;
    end else if (aluop == 2'b01) begin
      case (f3)
        3'b000: begin op = 4'b0110; res = a - b; tk = (a == b); end
        3'b001: begin op = 4'b0110; res = a - b; tk = (a != b); end
        3'b100: begin op = 4'b0110; res = a - b; tk = ($signed(a) < $signed(b)); end
        3'b101: begin op = 4'b0110; res = a - b; tk = ($signed(a) >= $signed(b)); end
        3'b110: begin op = 4'b0111; res = (a < b) ? 32'd1 : 32'd0; tk = (a < b); end
        3'b111: begin op = 4'b0111; res = (a < b) ? 32'd1 : 32'd0; tk = (a >= b); end
        default: ill = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000: begin
          if (aluop == 2'b10 && f7) begin op = 4'b0110; res = a - b; end
          else                      begin op = 4'b0010; res = a + b; end
        end
        3'b111: begin op = 4'b0000; res = a & b; end
        3'b110: begin op = 4'b0001; res = a | b; end
        3'b011: begin op = 4'b0111; res = (a < b) ? 32'd1 : 32'd0; end
        3'b010: begin op = 4'b0110; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
        default: ill = 1'b1;
      endcase
    end
    return {op, ill, tk, res};
  endfunction

  // One comparison with failure accounting
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one request, check latency, response fields, hold while stalled, and release
  task automatic run_req(input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                         input logic [DW-1:0] a, input logic [DW-1:0] b, input int hold);
    logic [EW-1:0] e;
    @(negedge clk);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1; req_aluop = aluop; req_funct3 = f3; req_funct7_5 = f7;
    req_a = a; req_b = b;
    exp_q.push_back(model(aluop, f3, f7, a, b));
    @(negedge clk);  // accepted on the edge just passed, now in EXEC
    req_valid = 1'b0;
    chk("rsp_valid_exec", {63'd0, rsp_valid}, 64'd0);
    chk("req_ready_exec", {63'd0, req_ready}, 64'd0);
    @(negedge clk);  // second edge after presenting the request: response valid
    chk("rsp_valid_resp", {63'd0, rsp_valid}, 64'd1);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      chk("alu_operation", {60'd0, alu_operation}, {60'd0, e[EW-1 -: 4]});
      chk("rsp_illegal",   {63'd0, rsp_illegal},   {63'd0, e[DW+1]});
      chk("rsp_taken",     {63'd0, rsp_taken},     {63'd0, e[DW]});
      chk("rsp_result",    {32'd0, rsp_result},    {32'd0, e[DW-1:0]});
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold_valid",  {63'd0, rsp_valid},  64'd1);
        chk("hold_result", {32'd0, rsp_result}, {32'd0, e[DW-1:0]});
        chk("hold_taken",  {63'd0, rsp_taken},  {63'd0, e[DW]});
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after", {63'd0, rsp_valid}, 64'd0);
    chk("req_ready_after", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_aluop = '0; req_funct3 = '0; req_funct7_5 = 1'b0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_alu_op",    {60'd0, alu_operation}, 64'd0);
    chk("rst_result",    {32'd0, rsp_result}, 64'd0);
    chk("rst_state",     {62'd0, dbg_state}, 64'd0);
    rst_n = 1'b1;

    run_req(2'b10, 3'b000, 1'b0, 32'd5, 32'd7, 0);                 // R ADD -> 12
    run_req(2'b10, 3'b000, 1'b1, 32'd5, 32'd7, 0);                 // R SUB -> FFFFFFFE
    run_req(2'b01, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);         // BLT taken
    run_req(2'b01, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 0);         // BLTU not taken
    run_req(2'b01, 3'b000, 1'b0, 32'h10, 32'h10, 3);               // BEQ, stalled 3 cycles
    run_req(2'b10, 3'b001, 1'b0, 32'd9, 32'd3, 1);                 // illegal R funct3
    run_req(2'b01, 3'b010, 1'b0, 32'd9, 32'd3, 0);                 // illegal branch funct3
    run_req(2'b00, 3'b010, 1'b1, 32'hFFFF_FFF0, 32'h20, 0);        // ld/st ADD wraps
    run_req(2'b11, 3'b000, 1'b1, 32'd5, 32'd7, 0);                 // I ADD ignores bit 30
    run_req(2'b10, 3'b010, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 0); // signed lt with overflow
    run_req(2'b11, 3'b011, 1'b0, 32'h8000_0000, 32'd1, 0);         // unsigned SLT
    run_req(2'b10, 3'b110, 1'b0, 32'hF0F0_0000, 32'h0000_0F0F, 0); // OR
    run_req(2'b11, 3'b111, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0); // AND
    run_req(2'b01, 3'b101, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 0); // BGE taken
    run_req(2'b01, 3'b111, 1'b0, 32'd3, 32'd3, 0);                 // BGEU taken
    run_req(2'b01, 3'b001, 1'b0, 32'd3, 32'd4, 0);                 // BNE taken

    // Reset while in EXEC drops the transaction
    @(negedge clk);
    req_valid = 1'b1; req_aluop = 2'b10; req_funct3 = 3'b000; req_funct7_5 = 1'b1;
    req_a = 32'd100; req_b = 32'd1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("pre_rst_state", {62'd0, dbg_state}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("exec_rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("exec_rst_ready", {63'd0, req_ready}, 64'd1);
    chk("exec_rst_op",    {60'd0, alu_operation}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", {63'd0, rsp_valid}, 64'd0);
    end

    // Random requests across all encodings
    for (int i = 0; i < 12; i++) begin
      run_req(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, int'($urandom_range(0, 2)));
    end

    chk("scoreboard_drained", {32'd0, 32'(exp_q.size())}, 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
